// File: rtl/uf_pkg.sv
// Shared command and state encodings for the union-find label table.
// Path compression is enabled by defining UF_PATH_COMPRESS_EN.
package uf_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR   = 2'b00,
        OP_UNION   = 2'b01,
        OP_FIND    = 2'b10,
        OP_FLATTEN = 2'b11
    } uf_op_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_RD_X,
        ST_CHK_X,
        ST_WB_X,
        ST_RD_Y,
        ST_CHK_Y,
        ST_WB_Y,
        ST_MERGE,
        ST_FL_RD,
        ST_FL_RDP,
        ST_FL_WR,
        ST_RESP
    } uf_state_e;

`ifdef UF_PATH_COMPRESS_EN
    localparam bit UF_COMPRESS = 1'b1;
`else
    localparam bit UF_COMPRESS = 1'b0;
`endif

endpackage

// File: rtl/uf_parent_ram.sv
// Single-port parent storage, N x ADDR_WIDTH, synchronous 1-cycle read.
module uf_parent_ram #(
    parameter int N          = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [ADDR_WIDTH-1:0] wdata,
    output logic [ADDR_WIDTH-1:0] rdata
);

    logic [ADDR_WIDTH-1:0] mem [N];
    logic [ADDR_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata_q   <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/uf_label_table.sv
// Union-find label table: min-index merge, optional path compression
// (UF_PATH_COMPRESS_EN), CLEAR / UNION / FIND / FLATTEN commands.
module uf_label_table
    import uf_pkg::*;
#(
    parameter int N          = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [1:0]            op,
    input  logic [ADDR_WIDTH-1:0] node1,
    input  logic [ADDR_WIDTH-1:0] node2,
    output logic                  rsp_valid,
    output logic [ADDR_WIDTH-1:0] rsp_root,
    output logic                  rsp_merged,
    output logic [ADDR_WIDTH:0]   rsp_count,
    output logic                  rsp_err
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N - 1);

    uf_state_e             state_q, state_d;
    uf_op_e                op_q, op_d;
    logic [ADDR_WIDTH-1:0] x_q, x_d, y_q, y_d, cur_q, cur_d, rx_q, rx_d, idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] res_root_q, res_root_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [1:0]            hops_q, hops_d;
    logic                  clr_rsp_q, clr_rsp_d, res_merged_q, res_merged_d, res_err_q, res_err_d;

    logic                  ram_en, ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr, ram_wdata, ram_rdata;
    logic                  at_root, need_wb, x_done, oob1, oob2;

    uf_parent_ram #(.N(N), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign at_root = (ram_rdata == cur_q);
    assign need_wb = UF_COMPRESS && hops_q[1];
    assign oob1    = (32'(node1) >= N);
    assign oob2    = (32'(node2) >= N);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_INIT;
            op_q         <= OP_CLEAR;
            x_q          <= '0;
            y_q          <= '0;
            cur_q        <= '0;
            rx_q         <= '0;
            idx_q        <= '0;
            res_root_q   <= '0;
            cnt_q        <= '0;
            hops_q       <= '0;
            clr_rsp_q    <= 1'b0;
            res_merged_q <= 1'b0;
            res_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            x_q          <= x_d;
            y_q          <= y_d;
            cur_q        <= cur_d;
            rx_q         <= rx_d;
            idx_q        <= idx_d;
            res_root_q   <= res_root_d;
            cnt_q        <= cnt_d;
            hops_q       <= hops_d;
            clr_rsp_q    <= clr_rsp_d;
            res_merged_q <= res_merged_d;
            res_err_q    <= res_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        x_d          = x_q;
        y_d          = y_q;
        cur_d        = cur_q;
        rx_d         = rx_q;
        idx_d        = idx_q;
        res_root_d   = res_root_q;
        cnt_d        = cnt_q;
        hops_d       = hops_q;
        clr_rsp_d    = clr_rsp_q;
        res_merged_d = res_merged_q;
        res_err_d    = res_err_q;
        x_done       = 1'b0;
        case (state_q)
            ST_IDLE: if (op_valid) begin
                op_d         = uf_op_e'(op);
                x_d          = node1;
                y_d          = node2;
                cur_d        = node1;
                hops_d       = '0;
                idx_d        = '0;
                cnt_d        = '0;
                res_root_d   = '0;
                res_merged_d = 1'b0;
                res_err_d    = 1'b0;
                if (((uf_op_e'(op) == OP_FIND || uf_op_e'(op) == OP_UNION) && oob1) ||
                    (uf_op_e'(op) == OP_UNION && oob2)) begin
                    res_err_d = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    case (uf_op_e'(op))
                        OP_CLEAR: begin
                            clr_rsp_d = 1'b1;
                            state_d   = ST_INIT;
                        end
                        OP_FLATTEN: state_d = ST_FL_RD;
                        default:    state_d = ST_RD_X;
                    endcase
                end
            end
            ST_INIT: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    idx_d     = '0;
                    clr_rsp_d = 1'b0;
                    state_d   = clr_rsp_q ? ST_RESP : ST_IDLE;
                end
            end
            ST_RD_X: state_d = ST_CHK_X;
            ST_CHK_X: begin
                if (!at_root) begin
                    cur_d   = ram_rdata;
                    hops_d  = hops_q[1] ? hops_q : hops_q + 1'b1;
                    state_d = ST_RD_X;
                end else if (need_wb) begin
                    state_d = ST_WB_X;
                end else begin
                    x_done = 1'b1;
                end
            end
            ST_WB_X: x_done = 1'b1;
            ST_RD_Y: state_d = ST_CHK_Y;
            ST_CHK_Y: begin
                if (!at_root) begin
                    cur_d   = ram_rdata;
                    hops_d  = hops_q[1] ? hops_q : hops_q + 1'b1;
                    state_d = ST_RD_Y;
                end else begin
                    state_d = need_wb ? ST_WB_Y : ST_MERGE;
                end
            end
            ST_WB_Y: state_d = ST_MERGE;
            ST_MERGE: begin
                res_root_d   = (rx_q < cur_q) ? rx_q : cur_q;
                res_merged_d = (rx_q != cur_q);
                state_d      = ST_RESP;
            end
            ST_FL_RD: state_d = ST_FL_RDP;
            ST_FL_RDP: begin
                if (ram_rdata == idx_q) cnt_d = cnt_q + 1'b1;
                state_d = ST_FL_WR;
            end
            ST_FL_WR: begin
                if (idx_q == LAST) begin
                    state_d = ST_RESP;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_FL_RD;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // cur_q holds the root of node1 both in CHK_X and in the following WB_X
        if (x_done) begin
            rx_d = cur_q;
            if (op_q == OP_FIND) begin
                res_root_d = cur_q;
                state_d    = ST_RESP;
            end else begin
                cur_d   = y_q;
                hops_d  = '0;
                state_d = ST_RD_Y;
            end
        end
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state_q)
            ST_INIT:  begin ram_en = 1'b1; ram_we = 1'b1; ram_addr = idx_q; ram_wdata = idx_q; end
            ST_RD_X,
            ST_RD_Y:  begin ram_en = 1'b1; ram_addr = cur_q; end
            ST_WB_X:  begin ram_en = 1'b1; ram_we = 1'b1; ram_addr = x_q; ram_wdata = cur_q; end
            ST_WB_Y:  begin ram_en = 1'b1; ram_we = 1'b1; ram_addr = y_q; ram_wdata = cur_q; end
            ST_MERGE: if (rx_q != cur_q) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = (rx_q < cur_q) ? cur_q : rx_q;
                ram_wdata = (rx_q < cur_q) ? rx_q : cur_q;
            end
            ST_FL_RD:  begin ram_en = 1'b1; ram_addr = idx_q; end
            ST_FL_RDP: begin ram_en = 1'b1; ram_addr = ram_rdata; end
            ST_FL_WR:  begin ram_en = 1'b1; ram_we = 1'b1; ram_addr = idx_q; ram_wdata = ram_rdata; end
            default: ;
        endcase
        if (reset) begin
            ram_en = 1'b0;
            ram_we = 1'b0;
        end
        op_ready   = (state_q == ST_IDLE) && !reset;
        rsp_valid  = (state_q == ST_RESP) && !reset;
        rsp_root   = rsp_valid ? res_root_q : '0;
        rsp_merged = rsp_valid && res_merged_q;
        rsp_count  = rsp_valid ? cnt_q : '0;
        rsp_err    = rsp_valid && res_err_q;
    end

endmodule

// File: tb/tb_uf_label_table.sv
// Directed scoreboard bench for uf_label_table (N=16 and N=12 instances).
module tb_uf_label_table;

    typedef struct {
        int         lat;
        logic [3:0] root;
        logic       merged;
        logic [4:0] count;
        logic       err;
    } exp_t;

`ifdef UF_PATH_COMPRESS_EN
    localparam int LAT_F7_DEEP = 8;
    localparam int LAT_F7_AGAIN = 5;
`else
    localparam int LAT_F7_DEEP = 7;
    localparam int LAT_F7_AGAIN = 7;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_op_valid = 1'b0, b_op_valid = 1'b0;
    logic [1:0] a_op = 2'b00, b_op = 2'b00;
    logic [3:0] a_n1 = '0, a_n2 = '0, b_n1 = '0, b_n2 = '0;
    logic       a_op_ready, a_rsp_valid, a_rsp_merged, a_rsp_err;
    logic       b_op_ready, b_rsp_valid, b_rsp_merged, b_rsp_err;
    logic [3:0] a_rsp_root, b_rsp_root;
    logic [4:0] a_rsp_count, b_rsp_count;

    int   n_vec = 0;
    int   n_miss = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    uf_label_table #(.N(16), .ADDR_WIDTH(4)) dut_a (
        .clk(clk), .reset(reset), .op_valid(a_op_valid), .op_ready(a_op_ready),
        .op(a_op), .node1(a_n1), .node2(a_n2), .rsp_valid(a_rsp_valid),
        .rsp_root(a_rsp_root), .rsp_merged(a_rsp_merged), .rsp_count(a_rsp_count),
        .rsp_err(a_rsp_err)
    );

    uf_label_table #(.N(12), .ADDR_WIDTH(4)) dut_b (
        .clk(clk), .reset(reset), .op_valid(b_op_valid), .op_ready(b_op_ready),
        .op(b_op), .node1(b_n1), .node2(b_n2), .rsp_valid(b_rsp_valid),
        .rsp_root(b_rsp_root), .rsp_merged(b_rsp_merged), .rsp_count(b_rsp_count),
        .rsp_err(b_rsp_err)
    );

    task automatic chk(input string tag, input int obs, input int expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(int lat, int root, int merged, int count, int err);
        exp_t e;
        e.lat = lat;
        e.root = 4'(root);
        e.merged = 1'(merged);
        e.count = 5'(count);
        e.err = 1'(err);
        return e;
    endfunction

    function automatic logic rdy(bit s);
        return s ? b_op_ready : a_op_ready;
    endfunction

    function automatic logic vld(bit s);
        return s ? b_rsp_valid : a_rsp_valid;
    endfunction

    task automatic run_cmd(input string tag, input bit s, input logic [1:0] op,
                           input logic [3:0] n1, input logic [3:0] n2, input exp_t e);
        int   w;
        int   lat;
        exp_t x;
        sb.push_back(e);
        w = 0;
        while (!rdy(s) && w < 1000) begin
            @(posedge clk); #1; w++;
        end
        chk({tag, "_ready"}, int'(rdy(s)), 1);
        if (s) begin b_op = op; b_n1 = n1; b_n2 = n2; b_op_valid = 1'b1; end
        else   begin a_op = op; a_n1 = n1; a_n2 = n2; a_op_valid = 1'b1; end
        @(posedge clk); #1;
        // operands change while busy; the block must not pick them up
        if (s) begin b_op_valid = 1'b0; b_op = ~op; b_n1 = ~n1; b_n2 = ~n2; end
        else   begin a_op_valid = 1'b0; a_op = ~op; a_n1 = ~n1; a_n2 = ~n2; end
        lat = 1;
        while (!vld(s) && lat < 400) begin
            @(posedge clk); #1; lat++;
        end
        x = sb.pop_front();
        chk({tag, "_valid"}, int'(vld(s)), 1);
        chk({tag, "_lat"}, lat, x.lat);
        chk({tag, "_root"}, int'(s ? b_rsp_root : a_rsp_root), int'(x.root));
        chk({tag, "_merged"}, int'(s ? b_rsp_merged : a_rsp_merged), int'(x.merged));
        chk({tag, "_count"}, int'(s ? b_rsp_count : a_rsp_count), int'(x.count));
        chk({tag, "_err"}, int'(s ? b_rsp_err : a_rsp_err), int'(x.err));
        @(posedge clk); #1;
        chk({tag, "_idle_out"}, int'({vld(s), s ? b_rsp_root : a_rsp_root}), 0);
    endtask

    initial begin
        int  cnt;
        bit  seen;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_a", int'(a_op_ready), 0);
        chk("rst_valid_a", int'(a_rsp_valid), 0);
        chk("rst_outs_a", int'({a_rsp_root, a_rsp_count, a_rsp_merged, a_rsp_err}), 0);
        chk("rst_ready_b", int'(b_op_ready), 0);
        reset = 1'b0;
        cnt = 0;
        while (!a_op_ready && cnt < 100) begin
            cnt++; @(posedge clk); #1;
        end
        chk("init_cycles", cnt, 16);

        run_cmd("find5", 0, 2'b10, 4'd5, 4'd0, mk(3, 5, 0, 0, 0));
        run_cmd("u37", 0, 2'b01, 4'd3, 4'd7, mk(6, 3, 1, 0, 0));
        run_cmd("find7_a", 0, 2'b10, 4'd7, 4'd0, mk(5, 3, 0, 0, 0));
        run_cmd("u37_rep", 0, 2'b01, 4'd3, 4'd7, mk(8, 3, 0, 0, 0));
        run_cmd("u72", 0, 2'b01, 4'd7, 4'd2, mk(8, 2, 1, 0, 0));
        run_cmd("find7_b", 0, 2'b10, 4'd7, 4'd0, mk(LAT_F7_DEEP, 2, 0, 0, 0));
        run_cmd("find7_c", 0, 2'b10, 4'd7, 4'd0, mk(LAT_F7_AGAIN, 2, 0, 0, 0));
        run_cmd("u9_12", 0, 2'b01, 4'd9, 4'd12, mk(6, 9, 1, 0, 0));
        run_cmd("flatten", 0, 2'b11, 4'd0, 4'd0, mk(49, 0, 0, 13, 0));
        run_cmd("find7_fl", 0, 2'b10, 4'd7, 4'd0, mk(5, 2, 0, 0, 0));
        run_cmd("find12_fl", 0, 2'b10, 4'd12, 4'd0, mk(5, 9, 0, 0, 0));
        run_cmd("u3_12", 0, 2'b01, 4'd3, 4'd12, mk(10, 2, 1, 0, 0));
        run_cmd("flatten2", 0, 2'b11, 4'd0, 4'd0, mk(49, 0, 0, 12, 0));
        run_cmd("clear", 0, 2'b00, 4'd0, 4'd0, mk(17, 0, 0, 0, 0));
        run_cmd("find3_clr", 0, 2'b10, 4'd3, 4'd0, mk(3, 3, 0, 0, 0));

        // abort a UNION in flight with reset
        run_cmd("u37_pre", 0, 2'b01, 4'd3, 4'd7, mk(6, 3, 1, 0, 0));
        a_op = 2'b01; a_n1 = 4'd7; a_n2 = 4'd4; a_op_valid = 1'b1;
        @(posedge clk); #1;
        a_op_valid = 1'b0;
        seen = 1'b0;
        repeat (2) begin
            seen |= a_rsp_valid; @(posedge clk); #1;
        end
        reset = 1'b1;
        repeat (3) begin
            seen |= a_rsp_valid | a_op_ready; @(posedge clk); #1;
        end
        reset = 1'b0;
        cnt = 0;
        while (!a_op_ready && cnt < 100) begin
            seen |= a_rsp_valid; cnt++; @(posedge clk); #1;
        end
        chk("abort_no_rsp", int'(seen), 0);
        chk("abort_init_cycles", cnt, 16);
        run_cmd("find7_rst", 0, 2'b10, 4'd7, 4'd0, mk(3, 7, 0, 0, 0));

        run_cmd("b_find14", 1, 2'b10, 4'd14, 4'd0, mk(1, 0, 0, 0, 1));
        run_cmd("b_u_oob2", 1, 2'b01, 4'd3, 4'd13, mk(1, 0, 0, 0, 1));
        run_cmd("b_u_oob1", 1, 2'b01, 4'd15, 4'd3, mk(1, 0, 0, 0, 1));
        run_cmd("b_find3", 1, 2'b10, 4'd3, 4'd0, mk(3, 3, 0, 0, 0));
        run_cmd("b_find11", 1, 2'b10, 4'd11, 4'd0, mk(3, 11, 0, 0, 0));
        run_cmd("b_u11_4", 1, 2'b01, 4'd11, 4'd4, mk(6, 4, 1, 0, 0));
        run_cmd("b_flatten", 1, 2'b11, 4'd0, 4'd0, mk(37, 0, 0, 11, 0));
        run_cmd("b_clear", 1, 2'b00, 4'd0, 4'd0, mk(13, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
